adc_spi_cmd_master: RTL and testbench

- SPI master (host end) for the ADC command/readback protocol served by the FPGA SPI slave.
- On `start`, transmits one complete ADC command packet, then polls for the waveform header and streams back `points` samples.
- Closes the exchange with the tail/acknowledge handshake.
- Used as an on-board initiator for a second FPGA or MCU-less test rig, and as the bench driver for the slave side.

---
 rtl/adc_proto_pkg.sv | 64 ++++++
 rtl/spi_word_master.sv | 97 +++++++++
 rtl/adc_spi_cmd_master.sv | 135 +++++++++++++
 tb/tb_adc_spi_cmd_master.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_proto_pkg.sv
// ADC command/readback protocol constants, FSM encodings and the
// command packet word table shared by the host-side SPI master.
package adc_proto_pkg;

   localparam logic [15:0] CMD_HEAD       = 16'hABCD;
   localparam logic [15:0] CMD_ADC        = 16'hFADC;
   localparam logic [15:0] CMD_ADC_SELECT = 16'hAF00;
   localparam logic [15:0] CMD_ADC_FREQ   = 16'hAF01;
   localparam logic [15:0] CMD_ADC_POINTS = 16'hAF02;
   localparam logic [15:0] CMD_TAIL       = 16'hCDEF;

   localparam logic [15:0] WAVE_HEAD = 16'hABCD;
   localparam logic [15:0] WAVE_TAIL = 16'hDCBA;
   localparam logic [15:0] HOST_ACK  = 16'hDCAB;

   localparam logic [15:0] ADC_9226_0 = 16'hADC0;
   localparam logic [15:0] ADC_9226_1 = 16'hADC1;

   localparam logic [3:0] CMD_LAST = 4'd9;

   localparam logic [1:0] ERR_OK      = 2'd0;
   localparam logic [1:0] ERR_TIMEOUT = 2'd1;
   localparam logic [1:0] ERR_TAIL    = 2'd2;

   typedef enum logic [2:0] {
      H_IDLE,
      H_CMD,
      H_POLL,
      H_READ,
      H_TAIL,
      H_ACK,
      H_DONE
   } host_state_e;

   typedef enum logic [2:0] {
      W_IDLE,
      W_LEAD,
      W_HIGH,
      W_LOW,
      W_TRAIL,
      W_GAP
   } word_state_e;

   function automatic logic [15:0] cmd_word(
      input logic [3:0]  idx,
      input logic [15:0] sel,
      input logic [31:0] freq,
      input logic [15:0] pts
   );
      case (idx)
         4'd0:    cmd_word = CMD_HEAD;
         4'd1:    cmd_word = CMD_ADC;
         4'd2:    cmd_word = CMD_ADC_SELECT;
         4'd3:    cmd_word = sel;
         4'd4:    cmd_word = CMD_ADC_FREQ;
         4'd5:    cmd_word = freq[31:16];
         4'd6:    cmd_word = freq[15:0];
         4'd7:    cmd_word = CMD_ADC_POINTS;
         4'd8:    cmd_word = pts;
         default: cmd_word = CMD_TAIL;
      endcase
   endfunction

endpackage

// File: rtl/spi_word_master.sv
// One 16-bit SPI mode-0 frame per load: CS_N low, 16 SCK pulses,
// trailing CS hold, then a CS_GAP idle gap before ready returns.
module spi_word_master
   import adc_proto_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int CS_GAP  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] tx_word,
   output logic        ready,
   output logic [15:0] rx_word,
   output logic        word_done,
   output logic        CS_N,
   output logic        SCK,
   output logic        MOSI,
   input  logic        MISO
);

   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
   localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);

   word_state_e state_q, state_d;

   logic [15:0] cnt_q;
   logic [14:0] sh_q;
   logic [15:0] rx_q;
   logic [3:0]  bit_q;
   logic        miso_q1, miso_q2;
   logic        tick, cs_n_d, sck_d;

   assign tick    = (cnt_q == DIV_LAST);
   assign rx_word = rx_q;

   always_ff @(posedge clk) begin
      if (rst) state_q <= W_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         W_IDLE:  if (load) state_d = W_LEAD;
         W_LEAD:  if (tick) state_d = W_HIGH;
         W_HIGH:  if (tick) state_d = (bit_q == 4'd15) ? W_TRAIL : W_LOW;
         W_LOW:   if (tick) state_d = W_HIGH;
         W_TRAIL: if (tick) state_d = W_GAP;
         W_GAP:   if (cnt_q == GAP_LAST) state_d = W_IDLE;
         default: state_d = W_IDLE;
      endcase
   end

   // Pins are registered from the next state so SCK/CS_N never glitch.
   always_comb begin
      ready  = (state_q == W_IDLE);
      cs_n_d = (state_d == W_IDLE) || (state_d == W_GAP);
      sck_d  = (state_d == W_HIGH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         sh_q      <= '0;
         rx_q      <= '0;
         bit_q     <= '0;
         miso_q1   <= 1'b0;
         miso_q2   <= 1'b0;
         CS_N      <= 1'b1;
         SCK       <= 1'b0;
         MOSI      <= 1'b0;
         word_done <= 1'b0;
      end else begin
         miso_q1   <= MISO;
         miso_q2   <= miso_q1;
         CS_N      <= cs_n_d;
         SCK       <= sck_d;
         word_done <= (state_q == W_TRAIL) && tick;
         cnt_q     <= (state_d != state_q) ? '0 : cnt_q + 16'd1;
         if ((state_q == W_IDLE) && load) begin
            sh_q  <= tx_word[14:0];
            MOSI  <= tx_word[15];
            bit_q <= '0;
         end
         // Taken at the end of the high phase: the synchroniser delay
         // still lands inside the window MISO was valid at the rise.
         if ((state_q == W_HIGH) && tick) begin
            rx_q  <= {rx_q[14:0], miso_q2};
            sh_q  <= {sh_q[13:0], 1'b0};
            MOSI  <= sh_q[14];
            bit_q <= bit_q + 4'd1;
         end
      end
   end

endmodule

// File: rtl/adc_spi_cmd_master.sv
// Host-side ADC SPI master: sends the command packet, polls for the
// waveform header, streams samples back and closes with tail/ack.
module adc_spi_cmd_master
   import adc_proto_pkg::*;
#(
   parameter int          CLK_DIV  = 4,
   parameter int          CS_GAP   = 4,
   parameter logic [15:0] POLL_MAX = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] adc_sel,
   input  logic [31:0] freq,
   input  logic [15:0] points,
   output logic        busy,
   output logic        done,
   output logic [1:0]  err,
   output logic        sample_valid,
   output logic [15:0] sample_data,
   output logic [15:0] sample_idx,
   output logic        CS_N,
   output logic        SCK,
   output logic        MOSI,
   input  logic        MISO
);

   host_state_e state_q, state_d;

   logic [15:0] sel_q, pts_q, cnt_q, poll_nxt;
   logic [31:0] freq_q;
   logic [15:0] tx_word, rx_word;
   logic        pend_q, load, ready, word_done, in_word;

   assign poll_nxt = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

   spi_word_master #(
      .CLK_DIV (CLK_DIV),
      .CS_GAP  (CS_GAP)
   ) u_word (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .tx_word   (tx_word),
      .ready     (ready),
      .rx_word   (rx_word),
      .word_done (word_done),
      .CS_N      (CS_N),
      .SCK       (SCK),
      .MOSI      (MOSI),
      .MISO      (MISO)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= H_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         H_IDLE: if (start) state_d = H_CMD;
         H_CMD:
            if (word_done && (cnt_q[3:0] == CMD_LAST))
               state_d = H_POLL;
         H_POLL:
            if (word_done) begin
               if (rx_word == WAVE_HEAD)
                  state_d = (pts_q == 16'd0) ? H_TAIL : H_READ;
               else if (poll_nxt == POLL_MAX)
                  state_d = H_DONE;
            end
         H_READ:
            if (word_done && (cnt_q + 16'd1 == pts_q))
               state_d = H_TAIL;
         H_TAIL:  if (word_done) state_d = H_ACK;
         H_ACK:   if (word_done) state_d = H_DONE;
         H_DONE:  state_d = H_IDLE;
         default: state_d = H_IDLE;
      endcase
   end

   always_comb begin
      busy    = (state_q != H_IDLE) && (state_q != H_DONE);
      done    = (state_q == H_DONE);
      in_word = busy;
      load    = in_word && !pend_q && ready;
      unique case (state_q)
         H_CMD:   tx_word = cmd_word(cnt_q[3:0], sel_q, freq_q, pts_q);
         H_ACK:   tx_word = HOST_ACK;
         default: tx_word = 16'h0000;
      endcase
   end

   // cnt_q is the command index, poll count or sample count by state.
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q        <= '0;
         freq_q       <= '0;
         pts_q        <= '0;
         cnt_q        <= '0;
         pend_q       <= 1'b0;
         err          <= ERR_OK;
         sample_valid <= 1'b0;
         sample_data  <= '0;
         sample_idx   <= '0;
      end else begin
         sample_valid <= 1'b0;
         if (load)           pend_q <= 1'b1;
         else if (word_done) pend_q <= 1'b0;
         if (state_d != state_q)
            cnt_q <= '0;
         else if (word_done)
            cnt_q <= (state_q == H_POLL) ? poll_nxt : cnt_q + 16'd1;
         if ((state_q == H_IDLE) && start) begin
            sel_q  <= adc_sel;
            freq_q <= freq;
            pts_q  <= points;
            err    <= ERR_OK;
         end
         if (word_done) begin
            if ((state_q == H_POLL) && (state_d == H_DONE))
               err <= ERR_TIMEOUT;
            if (state_q == H_READ) begin
               sample_valid <= 1'b1;
               sample_data  <= rx_word;
               sample_idx   <= cnt_q;
            end
            if (state_q == H_TAIL)
               err <= (rx_word == WAVE_TAIL) ? ERR_OK : ERR_TAIL;
         end
      end
   end

endmodule

// File: tb/tb_adc_spi_cmd_master.sv
// Scoreboard bench: behavioural SPI slave, MOSI/sample/done monitors.
module tb_adc_spi_cmd_master;

   localparam int          CLK_DIV  = 4;
   localparam int          CS_GAP   = 4;
   localparam logic [15:0] POLL_MAX = 16'd8;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [15:0] adc_sel, points;
   logic [31:0] freq;
   logic        busy, done, sample_valid;
   logic [1:0]  err;
   logic [15:0] sample_data, sample_idx;
   logic        CS_N, SCK, MOSI;
   logic        MISO = 1'b0;

   always #5 clk = ~clk;

   adc_spi_cmd_master #(
      .CLK_DIV  (CLK_DIV),
      .CS_GAP   (CS_GAP),
      .POLL_MAX (POLL_MAX)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .adc_sel      (adc_sel),
      .freq         (freq),
      .points       (points),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .sample_idx   (sample_idx),
      .CS_N         (CS_N),
      .SCK          (SCK),
      .MOSI         (MOSI),
      .MISO         (MISO)
   );

   int checks = 0;
   int errors = 0;

   logic [15:0] exp_mosi[$];
   logic [15:0] exp_sdata[$];
   logic [15:0] exp_sidx[$];
   logic [1:0]  exp_err[$];
   logic [15:0] reply_q[$];

   int     frames = 0;
   bit     abort_ok = 0;
   longint cyc = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input logic [31:0] act);
      checks++;
      errors++;
      $display("FAIL %s: got %h expected nothing", name, act);
   endtask

   // Slave model plus MOSI frame monitor, all on the falling clk edge.
   logic        cs_p = 1'b1, sck_p = 1'b0;
   logic [15:0] mosi_sh = '0, miso_w = '0;
   int          nbits = 0;
   longint      last_rise = 0;

   always @(negedge clk) begin
      cyc++;
      if (cs_p && !CS_N) begin
         frames++;
         nbits  = 0;
         miso_w = (reply_q.size() > 0) ? reply_q.pop_front() : 16'h0000;
         MISO   = miso_w[15];
      end
      if (!CS_N && !sck_p && SCK) begin
         if (nbits > 0)
            check("sck_period", 32'(cyc - last_rise), 32'(2 * CLK_DIV));
         last_rise = cyc;
         mosi_sh   = {mosi_sh[14:0], MOSI};
         nbits++;
      end
      if (!CS_N && sck_p && !SCK) begin
         miso_w = {miso_w[14:0], 1'b0};
         MISO   = miso_w[15];
      end
      if (!cs_p && CS_N) begin
         MISO = 1'b0;
         if (nbits == 16) begin
            if (exp_mosi.size() == 0) fail_now("mosi_extra_frame", mosi_sh);
            else check("mosi_word", mosi_sh, exp_mosi.pop_front());
         end else if (!abort_ok) begin
            fail_now("short_frame_bits", nbits);
         end
      end
      cs_p  = CS_N;
      sck_p = SCK;
   end

   always @(negedge clk) begin
      if (sample_valid) begin
         if (exp_sdata.size() == 0) begin
            fail_now("sample_extra", sample_data);
         end else begin
            check("sample_idx", sample_idx, exp_sidx.pop_front());
            check("sample_data", sample_data, exp_sdata.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (done) begin
         if (exp_err.size() == 0) begin
            fail_now("done_extra", err);
         end else begin
            check("err_at_done", err, exp_err.pop_front());
            check("busy_at_done", busy, 0);
         end
      end
   end

   task automatic push_cmd(input logic [15:0] s, input logic [31:0] f,
                           input logic [15:0] p);
      exp_mosi.push_back(16'hABCD);
      exp_mosi.push_back(16'hFADC);
      exp_mosi.push_back(16'hAF00);
      exp_mosi.push_back(s);
      exp_mosi.push_back(16'hAF01);
      exp_mosi.push_back(f[31:16]);
      exp_mosi.push_back(f[15:0]);
      exp_mosi.push_back(16'hAF02);
      exp_mosi.push_back(p);
      exp_mosi.push_back(16'hCDEF);
      for (int i = 0; i < 10; i++) reply_q.push_back(16'h0000);
   endtask

   task automatic push_zeros(input int n);
      for (int i = 0; i < n; i++) exp_mosi.push_back(16'h0000);
   endtask

   task automatic push_sample(input logic [15:0] idx,
                              input logic [15:0] d);
      reply_q.push_back(d);
      exp_sidx.push_back(idx);
      exp_sdata.push_back(d);
   endtask

   task automatic issue(input logic [15:0] s, input logic [31:0] f,
                        input logic [15:0] p);
      @(negedge clk);
      adc_sel = s;
      freq    = f;
      points  = p;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (!done) fail_now({name, "_done_timeout"}, n);
      repeat (300) @(negedge clk);
      check({name, "_mosi_left"}, exp_mosi.size(), 0);
      check({name, "_samples_left"}, exp_sdata.size(), 0);
      check({name, "_done_left"}, exp_err.size(), 0);
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      adc_sel = '0;
      freq    = '0;
      points  = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_cs_n", CS_N, 1);
      check("rst_sck", SCK, 0);
      check("rst_mosi", MOSI, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_sample_valid", sample_valid, 0);
      check("rst_sample_data", sample_data, 0);
      check("rst_sample_idx", sample_idx, 0);

      // Command encoding + readback, with an ignored start mid-run.
      push_cmd(16'hADC1, 32'h0003_0D40, 16'd4);
      reply_q.push_back(16'h0000);
      reply_q.push_back(16'h0000);
      reply_q.push_back(16'h0000);
      reply_q.push_back(16'hABCD);
      push_zeros(4);
      push_sample(16'd0, 16'h0111);
      push_sample(16'd1, 16'h0222);
      push_sample(16'd2, 16'h0333);
      push_sample(16'd3, 16'h0444);
      push_zeros(4);
      reply_q.push_back(16'hDCBA);
      push_zeros(1);
      reply_q.push_back(16'h0000);
      exp_mosi.push_back(16'hDCAB);
      exp_err.push_back(2'd0);
      issue(16'hADC1, 32'h0003_0D40, 16'd4);
      repeat (50) @(negedge clk);
      adc_sel = 16'hADC0;
      freq    = 32'hFFFF_FFFF;
      points  = 16'd9;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_hold", busy, 1);
      wait_done("readback");

      // Zero points: header goes straight to tail.
      push_cmd(16'hADC0, 32'h1234_5678, 16'd0);
      reply_q.push_back(16'hABCD);
      reply_q.push_back(16'hDCBA);
      reply_q.push_back(16'h0000);
      push_zeros(2);
      exp_mosi.push_back(16'hDCAB);
      exp_err.push_back(2'd0);
      issue(16'hADC0, 32'h1234_5678, 16'd0);
      wait_done("zero_points");

      // Header timeout: eight polls, no ack.
      push_cmd(16'hADC0, 32'h0000_0001, 16'd3);
      push_zeros(8);
      exp_err.push_back(2'd1);
      issue(16'hADC0, 32'h0000_0001, 16'd3);
      wait_done("timeout");

      // Bad tail word.
      push_cmd(16'hADC1, 32'h0000_00FF, 16'd2);
      reply_q.push_back(16'hABCD);
      push_zeros(1);
      push_sample(16'd0, 16'hAAAA);
      push_sample(16'd1, 16'hBBBB);
      push_zeros(2);
      reply_q.push_back(16'h1234);
      push_zeros(1);
      reply_q.push_back(16'h0000);
      exp_mosi.push_back(16'hDCAB);
      exp_err.push_back(2'd2);
      issue(16'hADC1, 32'h0000_00FF, 16'd2);
      wait_done("bad_tail");

      // Reset during command frame 5, then a full fresh transaction.
      begin
         int f0 = frames;
         int n  = 0;
         push_cmd(16'hADC1, 32'hCAFE_F00D, 16'd1);
         issue(16'hADC1, 32'hCAFE_F00D, 16'd1);
         while (frames < f0 + 5 && n < 5000) begin
            @(negedge clk);
            n++;
         end
         if (frames < f0 + 5) fail_now("frame5_wait", frames);
         repeat (30) @(negedge clk);
         abort_ok = 1;
         rst = 1'b1;
         @(negedge clk);
         check("midrst_cs_n", CS_N, 1);
         check("midrst_sck", SCK, 0);
         check("midrst_busy", busy, 0);
         rst = 1'b0;
         exp_mosi.delete();
         reply_q.delete();
         exp_sdata.delete();
         exp_sidx.delete();
         exp_err.delete();
         repeat (5) @(negedge clk);
         abort_ok = 0;
      end
      push_cmd(16'hADC0, 32'h0000_1388, 16'd1);
      reply_q.push_back(16'hABCD);
      push_zeros(1);
      push_sample(16'd0, 16'h5A5A);
      push_zeros(1);
      reply_q.push_back(16'hDCBA);
      push_zeros(1);
      reply_q.push_back(16'h0000);
      exp_mosi.push_back(16'hDCAB);
      exp_err.push_back(2'd0);
      issue(16'hADC0, 32'h0000_1388, 16'd1);
      wait_done("after_reset");

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
